// File: rtl/audio_i2s_pkg.sv
// Shared constants and state type for the I2S sample transmitter.
package audio_i2s_pkg;

    localparam int DEF_SAMPLE_W = 24;
    localparam int DEF_SLOT_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/bclk_tick_gen.sv
// BCLK divider: half-period counter with a one-cycle strobe on the 1->0 edge.
module bclk_tick_gen #(
    parameter int BCLK_HALF = 35
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    output logic bclk_o,
    output logic fall_tick_o
);
    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DW-1:0] LAST = DW'(BCLK_HALF - 1);

    logic [DW-1:0] div_q;
    logic          bclk_q;
    logic          wrap;

    assign wrap = (div_q == LAST);

    // Counter and BCLK are held at zero whenever the transmitter is not running.
    always_ff @(posedge clk_i) begin
        if (reset_i || !run_i) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (wrap) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q  <= div_q + DW'(1);
        end
    end

    // High in the cycle whose closing edge drives BCLK low.
    assign fall_tick_o = run_i && wrap && bclk_q;
    assign bclk_o      = bclk_q;

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S transmitter draining the sample FIFO: left/right pops, MSB-first
// serialization with the one-bit I2S delay, and low-watermark underrun handling.
module i2s_sample_tx
    import audio_i2s_pkg::*;
#(
    parameter int BCLK_HALF = 35,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int SLOT_W    = DEF_SLOT_W
) (
    input  logic                clk143,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] fifo_dout,
    input  logic                buf_lw,
    output logic                fifo_pop,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic [15:0]         underrun_cnt,
    output logic                playing
);
    localparam int BW = $clog2(2 * SLOT_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);
    localparam logic [BW-1:0] SAMP_B   = BW'(SAMPLE_W);

    tx_state_t           state_q, state_d;
    logic [BW-1:0]       bit_q, bit_d, nxt_bit, nxt_pos;
    logic                lrck_q, lrck_d;
    logic                dat_q, dat_d;
    logic [SAMPLE_W-1:0] sh_q, sh_d;
    logic [15:0]         ucnt_q, ucnt_d;
    logic                pop_d;
    logic                run, fall_tick;

    assign run = enable && (state_q != IDLE);

    bclk_tick_gen #(.BCLK_HALF(BCLK_HALF)) u_div (
        .clk_i      (clk143),
        .reset_i    (reset),
        .run_i      (run),
        .bclk_o     (aud_bclk),
        .fall_tick_o(fall_tick)
    );

    // Bit index and slot position the frame moves to on this fall tick.
    assign nxt_bit = (bit_q == LAST_BIT) ? '0 : bit_q + BW'(1);
    assign nxt_pos = (nxt_bit >= SLOT_B) ? nxt_bit - SLOT_B : nxt_bit;

    // Next-state: frame sequencing, sample loads, shifting and underrun decisions.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        lrck_d  = lrck_q;
        dat_d   = dat_q;
        sh_d    = sh_q;
        ucnt_d  = ucnt_q;
        pop_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = PRIME;
            end
            PRIME, RUN: begin
                if (fall_tick) begin
                    bit_d  = nxt_bit;
                    lrck_d = (nxt_bit >= SLOT_B);
                    if (nxt_pos == '0) begin
                        // Slot start: delay bit is 0, next word is captured.
                        dat_d = 1'b0;
                        sh_d  = '0;
                        if (state_q == PRIME) begin
                            if (nxt_bit == '0 && !buf_lw) begin
                                state_d = RUN;
                                pop_d   = 1'b1;
                                sh_d    = fifo_dout;
                            end
                        end else if (nxt_bit == '0 && buf_lw) begin
                            // Starved at a left load: mute the whole frame and re-prime.
                            state_d = PRIME;
                            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                        end else begin
                            pop_d = 1'b1;
                            sh_d  = fifo_dout;
                        end
                    end else if (nxt_pos <= SAMP_B) begin
                        dat_d = sh_q[SAMPLE_W-1];
                        sh_d  = {sh_q[SAMPLE_W-2:0], 1'b0};
                    end else begin
                        dat_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping enable parks everything except the underrun count.
        if (!enable) begin
            state_d = IDLE;
            bit_d   = '0;
            lrck_d  = 1'b0;
            dat_d   = 1'b0;
            sh_d    = '0;
            pop_d   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk143) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            lrck_q  <= 1'b0;
            dat_q   <= 1'b0;
            sh_q    <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            lrck_q  <= lrck_d;
            dat_q   <= dat_d;
            sh_q    <= sh_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign fifo_pop     = pop_d && !reset;
    assign aud_daclrck  = lrck_q;
    assign aud_dacdat   = dat_q;
    assign underrun_cnt = ucnt_q;
    assign playing      = (state_q == RUN);

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: FIFO model, slot-level scoreboard fed by directed
// stimulus, and a BCLK-sampling monitor that deserializes and compares each slot.
module tb_i2s_sample_tx;
    localparam int BH = 2;
    localparam int SW = 24;
    localparam int SL = 32;

    logic          clk143 = 1'b0;
    logic          reset = 1'b1, enable = 1'b0, buf_lw = 1'b0;
    logic [SW-1:0] fifo_dout = '0;
    logic          fifo_pop, aud_bclk, aud_daclrck, aud_dacdat, playing;
    logic [15:0]   underrun_cnt;

    always #5 clk143 = ~clk143;

    i2s_sample_tx #(.BCLK_HALF(BH), .SAMPLE_W(SW), .SLOT_W(SL)) dut (
        .clk143      (clk143),
        .reset       (reset),
        .enable      (enable),
        .fifo_dout   (fifo_dout),
        .buf_lw      (buf_lw),
        .fifo_pop    (fifo_pop),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .underrun_cnt(underrun_cnt),
        .playing     (playing)
    );

    // FIFO model: pointer moves one cycle after a pop, dout registered from it.
    logic [SW-1:0] mem [32];
    logic [4:0]    rd_ptr = '0;
    logic          pop_d1 = 1'b0;
    always @(posedge clk143) begin
        pop_d1 <= fifo_pop;
        if (pop_d1) rd_ptr <= rd_ptr + 5'd1;
        fifo_dout <= mem[rd_ptr];
    end

    typedef struct {
        logic          lr;
        logic [SW-1:0] s;
        int            pops;
    } slot_t;
    slot_t sb[$];

    int checks = 0, errors = 0, total_pops = 0, viol = 0;

    task automatic push(input logic lr, input logic [SW-1:0] s, input int pops);
        slot_t e;
        e.lr = lr; e.s = s; e.pops = pops;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_sb(input int left, input string tag);
        int n = 0;
        while (sb.size() > left && n < 3000) begin
            @(negedge clk143);
            n++;
        end
        checks++;
        if (sb.size() > left) begin
            errors++;
            $display("FAIL %s: timeout with %0d slots pending, expected %0d", tag, sb.size(), left);
            sb.delete();
        end
    endtask

    task automatic wait_bclk(input logic v, input string tag);
        int n = 0;
        while (aud_bclk !== v && n < 100) begin
            @(negedge clk143);
            n++;
        end
        if (aud_bclk !== v) begin
            checks++;
            errors++;
            $display("FAIL %s: BCLK stuck, got %b expected %b", tag, aud_bclk, v);
        end
    endtask

    // Monitor: sample data/LRCK on BCLK rising edges, assemble 32-bit slots,
    // count pops per slot window and compare against the scoreboard head.
    int          k = 0, slot_pops = 0, nslot = 0;
    logic [31:0] word = '0, exp_w;
    logic        lr_bad = 1'b0, prev_bclk = 1'b0, prev_pop = 1'b0;
    slot_t       e;
    always @(negedge clk143) begin
        if (fifo_pop) total_pops++;
        if (fifo_pop && (prev_pop || !enable || reset)) viol++;
        prev_pop = fifo_pop;
        if (reset || !enable) begin
            k = 0; word = '0; slot_pops = 0; lr_bad = 1'b0; prev_bclk = 1'b0;
        end else begin
            if (aud_bclk && !prev_bclk) begin
                if (aud_daclrck !== (k >= SL)) lr_bad = 1'b1;
                word = {word[30:0], aud_dacdat};
                if (k % SL == SL - 1) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        exp_w = {1'b0, e.s, {(SL-SW-1){1'b0}}};
                        checks++;
                        if (word !== exp_w || aud_daclrck !== e.lr || lr_bad || slot_pops != e.pops) begin
                            errors++;
                            $display("FAIL slot%0d: got word=%h lr=%b lr_glitch=%b pops=%0d, expected word=%h lr=%b pops=%0d",
                                     nslot, word, aud_daclrck, lr_bad, slot_pops, exp_w, e.lr, e.pops);
                        end
                        nslot++;
                    end
                    word = '0; slot_pops = 0; lr_bad = 1'b0;
                end
                k = (k + 1) % (2 * SL);
            end
            if (fifo_pop) slot_pops++;
            prev_bclk = aud_bclk;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = 24'hABCDEF; mem[1] = 24'h123456;
        mem[2] = 24'h800001; mem[3] = 24'h7FFFFE;
        mem[4] = 24'hFFFFFF; mem[5] = 24'h000001;
        mem[6] = 24'hFFFFFF;
        mem[7] = 24'h5A5A5A; mem[8] = 24'hA5A5A5;

        // Reset held with enable low.
        repeat (100) @(negedge clk143);
        check("rst_bclk", aud_bclk, 0);
        check("rst_lrck", aud_daclrck, 0);
        check("rst_dat", aud_dacdat, 0);
        check("rst_pops", total_pops, 0);
        check("rst_ucnt", underrun_cnt, 0);
        check("rst_playing", playing, 0);

        // Normal start: one primed silent frame, then L/R samples.
        @(posedge clk143); #1;
        reset = 1'b0; enable = 1'b1;
        push(0, 0, 0); push(1, 0, 0);
        push(0, 24'hABCDEF, 1); push(1, 24'h123456, 1);
        push(0, 24'h800001, 1); push(1, 24'h7FFFFE, 1);
        wait_sb(2, "first_frames");
        check("run_playing", playing, 1);

        // Starve during the right slot: right completes, next frame muted.
        wait_sb(1, "frame2_left");
        @(posedge clk143); #1 buf_lw = 1'b1;
        push(0, 0, 0); push(1, 0, 0); push(0, 0, 0);
        wait_sb(1, "underrun_frame");
        check("underrun_cnt1", underrun_cnt, 1);
        check("underrun_playing", playing, 0);
        push(1, 0, 0);
        wait_sb(1, "prime_hold");
        check("prime_bclk_runs", total_pops, 4);
        @(posedge clk143); #1 buf_lw = 1'b0;
        push(0, 24'hFFFFFF, 1); push(1, 24'h000001, 1);
        wait_sb(0, "resume");
        check("resume_playing", playing, 1);

        // Drop enable while BCLK is high in the middle of a left slot.
        wait_bclk(0, "frame6_start");
        repeat (40) @(negedge clk143);
        wait_bclk(1, "mid_left");
        enable = 1'b0;
        @(posedge clk143); #1;
        check("dis_bclk", aud_bclk, 0);
        check("dis_lrck", aud_daclrck, 0);
        check("dis_dat", aud_dacdat, 0);
        check("dis_playing", playing, 0);
        check("dis_ucnt_kept", underrun_cnt, 1);
        repeat (10) @(posedge clk143); #1;
        enable = 1'b1;
        push(0, 0, 0); push(1, 0, 0);
        push(0, 24'h5A5A5A, 1); push(1, 24'hA5A5A5, 1);
        wait_sb(0, "reenable");

        // Saturation: preload near the top, then three more underruns.
        wait_bclk(0, "sat_start");
        force dut.ucnt_q = 16'hFFFD;
        repeat (3) @(posedge clk143);
        #1 release dut.ucnt_q;
        repeat (100) @(posedge clk143); #1 buf_lw = 1'b1;
        repeat (256) @(posedge clk143); #1;
        check("sat_fffe", underrun_cnt, 16'hFFFE);
        buf_lw = 1'b0;
        repeat (256) @(posedge clk143); #1 buf_lw = 1'b1;
        repeat (256) @(posedge clk143); #1;
        check("sat_ffff", underrun_cnt, 16'hFFFF);
        buf_lw = 1'b0;
        repeat (256) @(posedge clk143); #1 buf_lw = 1'b1;
        repeat (256) @(posedge clk143); #1;
        check("sat_hold", underrun_cnt, 16'hFFFF);
        check("sat_playing", playing, 0);

        // Reset mid-frame clears everything including the counter.
        reset = 1'b1;
        @(posedge clk143); #1;
        check("mid_rst_ucnt", underrun_cnt, 0);
        check("mid_rst_bclk", aud_bclk, 0);
        check("mid_rst_pop", fifo_pop, 0);
        check("pop_rules", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
